// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed BCD 7-segment scanner with dead time, leading-zero blanking
// and frame-synchronous updates; define SEG7_HEX_EN to display codes 10..15 as A..F.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DEAD_CYC   = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    load,
    input  logic                    lz_blank,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = NUM_DIGITS > 2 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] hold_data, shadow_data;
    logic [NUM_DIGITS-1:0]   hold_dp, shadow_dp, lead;
    logic                    pend, slot_end, wrap, zero_run, cur_dp, cur_lead;
    logic [3:0]              cur_nib;
    logic [7:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_next;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
`ifdef SEG7_HEX_EN
            4'd10:   glyph = 7'h08;
            4'd11:   glyph = 7'h03;
            4'd12:   glyph = 7'h46;
            4'd13:   glyph = 7'h21;
            4'd14:   glyph = 7'h06;
            4'd15:   glyph = 7'h0E;
`endif
            default: glyph = 7'h7F;
        endcase
    endfunction

    assign slot_end = cnt == CNT_LAST;
    assign wrap     = slot_end && idx == IDX_LAST;

    // lead[k]: digit k and everything above it are zero with no decimal point lit
    always_comb begin
        lead     = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && shadow_data[4*k +: 4] == 4'd0 && !shadow_dp[k];
            lead[k]  = zero_run;
        end
        cur_nib  = '0;
        cur_dp   = 1'b0;
        cur_lead = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib  = shadow_data[4*k +: 4];
                cur_dp   = shadow_dp[k];
                cur_lead = lead[k];
            end
        end
        seg_next = cnt < CNT_DEAD ? 8'hFF : {~cur_dp, lz_blank && cur_lead ? 7'h7F : glyph(cur_nib)};
        an_next  = cnt < CNT_DEAD ? '1 : ~(NUM_DIGITS'(1) << idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            hold_data   <= '0;
            hold_dp     <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            pend        <= 1'b0;
            seg         <= 8'hFF;
            an          <= '1;
            frame_tick  <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= idx >= IDX_LAST ? '0 : idx + 1'b1;
            if (load) begin
                hold_data <= data;
                hold_dp   <= dp_mask;
            end
            // shadow takes the hold value from before this edge, so a same-cycle load waits a frame
            if (wrap && pend) begin
                shadow_data <= hold_data;
                shadow_dp   <= hold_dp;
            end
            pend       <= load || (pend && !wrap);
            seg        <= seg_next;
            an         <= an_next;
            frame_tick <= wrap;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: random and directed stimulus checked every cycle against a
// cycle-count-based display model, plus literal glyph checks from the test plan.
module tb_seg7_scan_driver;
    localparam int ND = 4;
    localparam int SD = 4;
    localparam int DC = 1;
    localparam int FR = SD * ND;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp_mask = '0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    int total = 0;
    int bad = 0;
    int e = 0;
    logic [15:0] m_hd, m_sd;
    logic [3:0]  m_hp, m_sp;
    logic        m_pend;
    logic [7:0]  tbl [16];
    logic [7:0]  cap [4];
    logic [3:0]  an_seq [8];
    logic        lz_cur = 1'b0;

    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYC(DC)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .dp_mask(dp_mask), .load(load),
        .lz_blank(lz_blank), .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at e=%0d: got %h expected %h", name, e, got, exp);
        end
    endtask

    task automatic model_reset();
        e = 0; m_hd = '0; m_sd = '0; m_hp = '0; m_sp = '0; m_pend = 1'b0;
    endtask

    // one clock: drive at negedge, predict at posedge, compare at next negedge
    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] dp, input logic lz);
        int pos, dig;
        logic [7:0] es;
        logic [3:0] ea, nib;
        logic ef, blank;
        load = ld; data = d; dp_mask = dp; lz_blank = lz;
        @(posedge clk);
        pos   = e % SD;
        dig   = (e / SD) % ND;
        nib   = 4'((m_sd >> (4 * dig)) & 16'hF);
        blank = lz && dig > 0 && (m_sd >> (4 * dig)) == 16'h0 && (m_sp >> dig) == 4'h0;
        ea    = pos < DC ? 4'hF : ~(4'b1 << dig);
        es    = pos < DC ? 8'hFF : {~m_sp[dig], blank ? 7'h7F : tbl[nib][6:0]};
        ef    = (e % FR) == FR - 1;
        if (ef && m_pend) begin
            m_sd = m_hd;
            m_sp = m_hp;
        end
        m_pend = ld ? 1'b1 : (ef ? 1'b0 : m_pend);
        if (ld) begin
            m_hd = d;
            m_hp = dp;
        end
        e++;
        @(negedge clk);
        chk("seg", seg, es);
        chk("an", 8'(an), 8'(ea));
        chk("frame_tick", 8'(frame_tick), 8'(ef));
    endtask

    // one frame aligned to a wrap; optional loads at slots la and lb, glyphs captured per digit
    task automatic frame(input int la, input logic [15:0] da, input logic [3:0] pa,
                         input int lb, input logic [15:0] db, input logic lz);
        for (int k = 0; k < 4; k++) cap[k] = 8'h00;
        for (int i = 0; i < FR; i++) begin
            if (i == la) step(1'b1, da, pa, lz);
            else if (i == lb) step(1'b1, db, 4'h0, lz);
            else step(1'b0, 16'h0, 4'h0, lz);
            for (int k = 0; k < 4; k++) if (an[k] == 1'b0) cap[k] = seg;
            if (i == FR - 1) chk("tick_at_wrap", 8'(frame_tick), 8'h01);
        end
    endtask

    task automatic chk_cap(input string name, input logic [7:0] c3, input logic [7:0] c2,
                           input logic [7:0] c1, input logic [7:0] c0);
        chk({name, "_d3"}, cap[3], c3);
        chk({name, "_d2"}, cap[2], c2);
        chk({name, "_d1"}, cap[1], c1);
        chk({name, "_d0"}, cap[0], c0);
    endtask

    initial begin
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90,
`ifdef SEG7_HEX_EN
                8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
`else
                8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`endif
        an_seq = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD};
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_seg", seg, 8'hFF);
        chk("reset_an", 8'(an), 8'h0F);
        chk("reset_tick", 8'(frame_tick), 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 16'h0, 4'h0, 1'b0);
            chk("an_seq", 8'(an), 8'(an_seq[i]));
        end
        repeat (8) step(1'b0, 16'h0, 4'h0, 1'b0);

        frame(2, 16'h1234, 4'b0100, -1, 16'h0, 1'b0);
        chk("old_until_tick", cap[3], 8'hC0);
        frame(-1, 16'h0, 4'h0, -1, 16'h0, 1'b0);
        chk_cap("v1234", 8'hF9, 8'h24, 8'hB0, 8'h99);
        frame(4, 16'h5678, 4'h0, 8, 16'h9999, 1'b0);
        chk_cap("tearfree_old", 8'hF9, 8'h24, 8'hB0, 8'h99);
        frame(-1, 16'h0, 4'h0, -1, 16'h0, 1'b0);
        chk_cap("tearfree_new", 8'h90, 8'h90, 8'h90, 8'h90);

        frame(0, 16'h0007, 4'h0, -1, 16'h0, 1'b1);
        frame(-1, 16'h0, 4'h0, -1, 16'h0, 1'b1);
        chk_cap("lz_0007", 8'hFF, 8'hFF, 8'hFF, 8'hF8);
        frame(0, 16'h0000, 4'h0, -1, 16'h0, 1'b1);
        frame(-1, 16'h0, 4'h0, -1, 16'h0, 1'b1);
        chk_cap("lz_0000", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
        frame(0, 16'h0005, 4'b0010, -1, 16'h0, 1'b1);
        frame(-1, 16'h0, 4'h0, -1, 16'h0, 1'b1);
        chk_cap("lz_dp", 8'hFF, 8'hFF, 8'h40, 8'h92);
        frame(0, 16'h00AF, 4'h0, -1, 16'h0, 1'b0);
        frame(-1, 16'h0, 4'h0, -1, 16'h0, 1'b0);
`ifdef SEG7_HEX_EN
        chk_cap("hex", 8'hC0, 8'hC0, 8'h88, 8'h8E);
`else
        chk_cap("hex", 8'hC0, 8'hC0, 8'hFF, 8'hFF);
`endif
        frame(3, 16'h1111, 4'h0, FR - 1, 16'h2222, 1'b0);
        frame(-1, 16'h0, 4'h0, -1, 16'h0, 1'b0);
        chk_cap("wrap_load_old", 8'hF9, 8'hF9, 8'hF9, 8'hF9);
        frame(-1, 16'h0, 4'h0, -1, 16'h0, 1'b0);
        chk_cap("wrap_load_new", 8'hA4, 8'hA4, 8'hA4, 8'hA4);

        for (int i = 0; i < 1500; i++) begin
            logic [15:0] d;
            logic [3:0]  p;
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 0) d = d & (16'hFFFF >> (4 * $urandom_range(1, 4)));
            p = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 15) == 0) lz_cur = ~lz_cur;
            step($urandom_range(0, 7) == 0, d, p, lz_cur);
        end

        for (int i = 0; i < SD && (e % SD) != 2; i++) step(1'b0, 16'h0, 4'h0, lz_cur);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_seg", seg, 8'hFF);
        chk("midreset_an", 8'(an), 8'h0F);
        chk("midreset_tick", 8'(frame_tick), 8'h00);
        @(negedge clk);
        chk("midreset_hold_an", 8'(an), 8'h0F);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 16'h0, 4'h0, 1'b0);
            chk("an_seq2", 8'(an), 8'(an_seq[i]));
        end
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) lz_cur = ~lz_cur;
            step($urandom_range(0, 5) == 0, 16'($urandom), 4'($urandom_range(0, 1) ? 0 : $urandom), lz_cur);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Multi-digit time-multiplexed 7-segment driver and successor to the single-digit decoder. It holds a BCD word for NUM_DIGITS digits and scans one digit per slot. For each digit it decodes the value and drives the shared active-low segment bus plus a per-digit active-low anode. It adds per-digit decimal points, leading-zero blanking, anti-ghosting dead time and tear-free frame-synchronous updates. It sits between the temperature/value formatting logic and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
SCAN_DIV, 50000, clocks per digit slot (>= DEAD_CYC+2)
DEAD_CYC, 500, clocks at start of each slot with all anodes off (>= 1)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
DATA  in  4*NUM_DIGITS  BCD digits; nibble k = digit k, digit 0 least significant
DP_MASK  in  NUM_DIGITS  bit k=1 lights the decimal point of digit k
LOAD  in  1  one-cycle strobe; captures DATA/DP_MASK into the hold register
LZ_BLANK  in  1  1 = enable leading-zero blanking (sampled live)
SEG  out  8  active-low segments; bit7=dp, bits6..0=g..a
AN  out  NUM_DIGITS  active-low digit enables, one-hot-low or all-high
FRAME_TICK  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset (async, RST_N=0): SEG=8'hFF, AN=all 1, FRAME_TICK=0, slot counter cnt=0, digit index idx=0, hold=0, shadow=0, pend=0. Release is synchronous to the next CLK edge. Reset mid-scan aborts the scan immediately with outputs off.
- Slot counter: cnt counts 0..SCAN_DIV-1 and wraps. At cnt==SCAN_DIV-1, idx increments. idx wraps from NUM_DIGITS-1 to 0, scanning from the LSB digit up.
- Frame wrap (cnt==SCAN_DIV-1 and idx==NUM_DIGITS-1): FRAME_TICK=1 on the following cycle, for one cycle only.
- Load path:
  - LOAD=1 copies DATA/DP_MASK into hold and sets pend=1.
  - On a frame wrap with pend=1, shadow<=hold and pend<=0.
  - The display only ever shows shadow, so there is no tearing within a frame.
  - LOAD on the same cycle as a frame wrap: shadow takes the previous hold if pend was set; the new value goes into hold and pend stays 1 for the next frame.
  - Repeated LOADs within a frame: the last one wins.
- Dead time:
  - While cnt<DEAD_CYC: AN=all 1 and SEG=8'hFF.
  - Otherwise: AN[idx]=0 and all other AN bits are 1.
- Decode, active-low, dp bit7 cleared when shadow DP_MASK[idx]=1:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - 10..15 decode to 8'hFF (blank) unless SEG7_HEX_EN is defined.
  - The dp rule still applies to blanked codes.
- Leading-zero blanking (LZ_BLANK=1):
  - Digit k is blanked (bits6..0=1) if its value and every higher digit j>k are 0 and no DP bit is set at any j>=k.
  - Digit 0 is never blanked.
  - Blanked digits keep AN timing unchanged.
- Latency: SEG/AN/FRAME_TICK are registered, lagging cnt/idx by exactly 1 clock. SEG and AN always change on the same edge.
- Arithmetic:
  - cnt width is clog2(SCAN_DIV); idx width is clog2(NUM_DIGITS), minimum 1.
  - There are no out-of-range idx states; any illegal value is forced to 0 on the next slot end.

Optional Feature:
SEG7_HEX_EN
- Defined: codes 10..15 decode to A=88, b=83, C=C6, d=A1, E=86, F=8E. Leading-zero blanking treats these as nonzero.
- Undefined: codes 10..15 decode to blank (8'hFF apart from dp); no hex logic is synthesised.

Test Plan:
- Reset and scan, with NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYC=1:
  - Hold RST_N=0 mid-scan -> SEG=FF and AN=1111 immediately.
  - Release -> AN sequence 1111, 1110 ×3, 1111, 1101 ×3, …; FRAME_TICK pulses once every 16 clocks.
- Load value 0x1234 with DP_MASK=0100, LOAD=1 -> display changes only after the next FRAME_TICK. Digit 0 SEG=99, digit 1 SEG=B0, digit 2 SEG=24 (dp lit), digit 3 SEG=F9.
- Tear-free update: LOAD 0x5678 at idx=1, then LOAD 0x9999 at idx=2 in the same frame -> the current frame still shows the old value; the next frame shows 9999 (SEG=90 on all digits).
- Leading-zero blanking: DATA=0x0007, DP_MASK=0000, LZ_BLANK=1 -> digits 3..1 SEG=FF, digit 0 SEG=F8. DATA=0x0000 -> only digit 0 shows C0. DATA=0x0005 with DP_MASK=0010 -> digit 1 shows 40.
- Codes 10..15: DATA=0x00AF, LZ_BLANK=0 -> with SEG7_HEX_EN defined, digit 0=8E and digit 1=88; without it, both are FF and digits 2..3 show C0.
- Simultaneous events: LOAD on the exact frame-wrap cycle with pend=1 -> shadow gets the older hold. The new value appears one frame later, and FRAME_TICK is unaffected.
